// File: rtl/switch_fabric_if.sv
// Ingress/egress signal bundle for switch_fabric.
// in_prio exists only when SWITCH_FABRIC_PRIO_EN is defined.
interface switch_fabric_if #(
    parameter int unsigned NPORTS = 8,
    parameter int unsigned AW     = 4,
    parameter int unsigned DW     = 32
);
    logic [NPORTS-1:0]    in_vld;
    logic [NPORTS*AW-1:0] in_addr;
    logic [NPORTS*DW-1:0] in_data;
    logic [NPORTS-1:0]    in_rdy;
    logic [NPORTS-1:0]    out_pop;
    logic [NPORTS*DW-1:0] out_data;
    logic [NPORTS-1:0]    out_empty;
    logic [NPORTS-1:0]    out_full;
    logic                 drop_err;

`ifdef SWITCH_FABRIC_PRIO_EN
    logic [NPORTS-1:0]    in_prio;

    modport master (
        output in_vld, in_addr, in_data, in_prio, out_pop,
        input  in_rdy, out_data, out_empty, out_full, drop_err
    );
    modport slave (
        input  in_vld, in_addr, in_data, in_prio, out_pop,
        output in_rdy, out_data, out_empty, out_full, drop_err
    );
`else
    modport master (
        output in_vld, in_addr, in_data, out_pop,
        input  in_rdy, out_data, out_empty, out_full, drop_err
    );
    modport slave (
        input  in_vld, in_addr, in_data, out_pop,
        output in_rdy, out_data, out_empty, out_full, drop_err
    );
`endif
endinterface

// File: rtl/switch_fabric.sv
// Crossbar core: per-output round-robin arbiters feeding per-output show-ahead FIFOs.
// Optional SWITCH_FABRIC_PRIO_EN adds a priority class (in_prio) ahead of round-robin.
module switch_fabric #(
    parameter int unsigned NPORTS = 8,
    parameter int unsigned AW     = 4,
    parameter int unsigned DW     = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    switch_fabric_if.slave  bus
);
    localparam int unsigned RRW = $clog2(NPORTS);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned AX  = AW + 1;

    logic [RRW-1:0]    rr      [NPORTS];
    logic [PW-1:0]     wr_ptr  [NPORTS];
    logic [PW-1:0]     rd_ptr  [NPORTS];
    logic [CW-1:0]     cnt     [NPORTS];
    logic [DW-1:0]     mem     [NPORTS][DEPTH];
    logic [DW-1:0]     head    [NPORTS];
    logic [NPORTS-1:0] empty;
    logic [NPORTS-1:0] full;
    logic              drop;

    logic [NPORTS-1:0] addr_ok_c;
    logic [NPORTS-1:0] req_c       [NPORTS];
    logic [NPORTS-1:0] gnt_vld_c;
    logic [RRW-1:0]    gnt_idx_c   [NPORTS];
    logic [RRW-1:0]    rr_next_c   [NPORTS];
    logic [NPORTS-1:0] rdy_c;
    logic [NPORTS-1:0] push_c;
    logic [NPORTS-1:0] pop_c;
    logic [DW-1:0]     push_data_c [NPORTS];
    logic [CW-1:0]     cnt_next_c  [NPORTS];
    logic [DW-1:0]     head_next_c [NPORTS];
    logic              drop_c;

    // Address decode: req_c[o][i] is input i asking for output o
    always_comb begin : decode
        for (int i = 0; i < NPORTS; i++) begin
            addr_ok_c[i] = {1'b0, bus.in_addr[i*AW +: AW]} < AX'(NPORTS);
        end
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                req_c[o][i] = bus.in_vld[i] && (bus.in_addr[i*AW +: AW] == AW'(o));
            end
        end
    end

    // Round-robin: lowest requester at or above rr[o], else lowest requester overall
    always_comb begin : arbiter
        logic [NPORTS-1:0] cls;
        logic              hi_hit;
        logic              lo_hit;
        logic [RRW-1:0]    hi_idx;
        logic [RRW-1:0]    lo_idx;
        for (int o = 0; o < NPORTS; o++) begin
            gnt_vld_c[o] = 1'b0;
            gnt_idx_c[o] = '0;
            hi_hit       = 1'b0;
            lo_hit       = 1'b0;
            hi_idx       = '0;
            lo_idx       = '0;
`ifdef SWITCH_FABRIC_PRIO_EN
            cls = req_c[o] & bus.in_prio;
            if (cls == '0) begin
                cls = req_c[o];
            end
`else
            cls = req_c[o];
`endif
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (cls[i]) begin
                    lo_hit = 1'b1;
                    lo_idx = RRW'(i);
                    if (RRW'(i) >= rr[o]) begin
                        hi_hit = 1'b1;
                        hi_idx = RRW'(i);
                    end
                end
            end
            if (!full[o] && (hi_hit || lo_hit)) begin
                gnt_vld_c[o] = 1'b1;
                gnt_idx_c[o] = hi_hit ? hi_idx : lo_idx;
            end
            rr_next_c[o] = (gnt_idx_c[o] == RRW'(NPORTS - 1)) ? '0 : gnt_idx_c[o] + RRW'(1);
        end
    end

    // Handshake, FIFO occupancy and next head-of-queue
    always_comb begin : datapath
        drop_c = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            rdy_c[i] = !addr_ok_c[i];
            drop_c   = drop_c | (bus.in_vld[i] & !addr_ok_c[i]);
        end
        for (int o = 0; o < NPORTS; o++) begin
            push_c[o]      = gnt_vld_c[o];
            pop_c[o]       = bus.out_pop[o] && !empty[o];
            push_data_c[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (gnt_vld_c[o] && (gnt_idx_c[o] == RRW'(i))) begin
                    rdy_c[i]       = 1'b1;
                    push_data_c[o] = bus.in_data[i*DW +: DW];
                end
            end
            case ({push_c[o], pop_c[o]})
                2'b10:   cnt_next_c[o] = cnt[o] + CW'(1);
                2'b01:   cnt_next_c[o] = cnt[o] - CW'(1);
                default: cnt_next_c[o] = cnt[o];
            endcase
            // Show-ahead: head follows the entry behind a pop, or a push into an emptying FIFO
            head_next_c[o] = head[o];
            if (pop_c[o] && (cnt[o] > CW'(1))) begin
                head_next_c[o] = mem[o][rd_ptr[o] + PW'(1)];
            end else if (push_c[o] && (empty[o] || pop_c[o])) begin
                head_next_c[o] = push_data_c[o];
            end
        end
        rdy_c = rdy_c & {NPORTS{reset_n}};
    end

    always_ff @(posedge clock or negedge reset_n) begin : ctrl_regs
        if (!reset_n) begin
            for (int o = 0; o < NPORTS; o++) begin
                rr[o]     <= '0;
                wr_ptr[o] <= '0;
                rd_ptr[o] <= '0;
                cnt[o]    <= '0;
                head[o]   <= '0;
            end
            empty <= '1;
            full  <= '0;
            drop  <= 1'b0;
        end else begin
            drop <= drop_c;
            for (int o = 0; o < NPORTS; o++) begin
                if (push_c[o]) begin
                    wr_ptr[o] <= wr_ptr[o] + PW'(1);
                    rr[o]     <= rr_next_c[o];
                end
                if (pop_c[o]) begin
                    rd_ptr[o] <= rd_ptr[o] + PW'(1);
                end
                cnt[o]   <= cnt_next_c[o];
                head[o]  <= head_next_c[o];
                empty[o] <= (cnt_next_c[o] == '0);
                full[o]  <= (cnt_next_c[o] == CW'(DEPTH));
            end
        end
    end

    // Storage array carries no reset; occupancy state guards every read
    always_ff @(posedge clock) begin : fifo_mem
        for (int o = 0; o < NPORTS; o++) begin
            if (push_c[o]) begin
                mem[o][wr_ptr[o]] <= push_data_c[o];
            end
        end
    end

    assign bus.in_rdy    = rdy_c;
    assign bus.out_empty = empty;
    assign bus.out_full  = full;
    assign bus.drop_err  = drop;

    for (genvar g = 0; g < NPORTS; g++) begin : g_out
        assign bus.out_data[g*DW +: DW] = head[g];
    end
endmodule

// File: tb/tb_switch_fabric.sv
// Scoreboard bench for switch_fabric: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_switch_fabric;
    localparam int unsigned N     = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    switch_fabric_if #(.NPORTS(N), .AW(AW), .DW(DW)) bus ();

    switch_fabric #(.NPORTS(N), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per output FIFO, one integer pointer per arbiter
    logic [DW-1:0] exp_q [N][$];
    int            rr_m  [N];
    logic          exp_drop = 1'b0;
    int            gnt_log [$];
    logic [N-1:0]  acc = '0;
    int            exp_g [6] = '{1, 3, 6, 1, 3, 6};

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: compares DUT against the model between edges, then advances the model
    always @(negedge clock) begin : monitor
        logic [N-1:0] req;
        logic [N-1:0] exp_rdy;
        int           w [N];
        if (!reset_n) begin
            check("rst_in_rdy", 0, bus.in_rdy, '0);
            check("rst_out_empty", 0, bus.out_empty, {N{1'b1}});
            check("rst_out_full", 0, bus.out_full, '0);
            check("rst_drop_err", 0, bus.drop_err, 1'b0);
            for (int o = 0; o < N; o++) begin
                check("rst_out_data", o, bus.out_data[o*DW +: DW], '0);
                exp_q[o].delete();
                rr_m[o] = 0;
            end
            exp_drop = 1'b0;
        end else begin
            check("drop_err", 0, bus.drop_err, exp_drop);
            for (int o = 0; o < N; o++) begin
                check("out_empty", o, bus.out_empty[o], exp_q[o].size() == 0);
                check("out_full", o, bus.out_full[o], exp_q[o].size() == DEPTH);
                if (exp_q[o].size() > 0)
                    check("out_data", o, bus.out_data[o*DW +: DW], exp_q[o][0]);
            end
            exp_rdy  = '0;
            exp_drop = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (int'(bus.in_addr[i*AW +: AW]) >= N) begin
                    exp_rdy[i] = 1'b1;
                    if (bus.in_vld[i]) exp_drop = 1'b1;
                end
            end
            for (int o = 0; o < N; o++) begin
                req = '0;
                for (int i = 0; i < N; i++)
                    if (bus.in_vld[i] && int'(bus.in_addr[i*AW +: AW]) == o) req[i] = 1'b1;
`ifdef SWITCH_FABRIC_PRIO_EN
                if ((req & bus.in_prio) != '0) req = req & bus.in_prio;
`endif
                w[o] = (exp_q[o].size() == DEPTH) ? -1 : pick(req, rr_m[o]);
                if (w[o] >= 0) exp_rdy[w[o]] = 1'b1;
            end
            check("in_rdy", 0, bus.in_rdy, exp_rdy);
            for (int o = 0; o < N; o++) begin
                if (bus.out_pop[o] && exp_q[o].size() > 0) void'(exp_q[o].pop_front());
                if (w[o] >= 0) begin
                    exp_q[o].push_back(bus.in_data[w[o]*DW +: DW]);
                    rr_m[o] = (w[o] + 1) % N;
                    if (o == 0) gnt_log.push_back(w[o]);
                end
            end
        end
    end

    // One cycle: record acceptances before the edge, return just after it
    task automatic step();
        @(negedge clock);
        acc = bus.in_vld & bus.in_rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input int i, input logic v, input int a, input logic [DW-1:0] d);
        bus.in_vld[i]          = v;
        bus.in_addr[i*AW +: AW] = AW'(a);
        bus.in_data[i*DW +: DW] = d;
    endtask

    initial begin : stimulus
        int acc_cnt [N];
        int sent;
        int r;
        bus.in_vld  = '1;
        bus.in_addr = '0;
        bus.in_data = '0;
        bus.out_pop = '0;
`ifdef SWITCH_FABRIC_PRIO_EN
        bus.in_prio = '0;
`endif
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        reset_n    = 1'b1;
        bus.in_vld = '0;
        step();

        // Single path: input 2 -> output 5
        set_in(2, 1'b1, 5, 32'hA5A5_0001);
        step();
        check("sp_accept", 2, acc[2], 1'b1);
        check("sp_empty", 5, bus.out_empty[5], 1'b0);
        check("sp_data", 5, bus.out_data[5*DW +: DW], 32'hA5A5_0001);
        bus.in_vld[2]  = 1'b0;
        bus.out_pop[5] = 1'b1;
        step();
        bus.out_pop[5] = 1'b0;
        check("sp_pop_empty", 5, bus.out_empty[5], 1'b1);

        // Contention: inputs 1, 3, 6 all to output 0, drained every cycle
        gnt_log.delete();
        foreach (acc_cnt[i]) acc_cnt[i] = 0;
        set_in(1, 1'b1, 0, 32'hC000_0100);
        set_in(3, 1'b1, 0, 32'hC000_0300);
        set_in(6, 1'b1, 0, 32'hC000_0600);
        bus.out_pop[0] = 1'b1;
        repeat (12) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    acc_cnt[i]++;
                    bus.in_data[i*DW +: DW] = bus.in_data[i*DW +: DW] + 32'd1;
                end
            end
        end
        bus.in_vld = '0;
        check("cont_log_len", 0, gnt_log.size() >= 6, 1'b1);
        if (gnt_log.size() >= 6)
            for (int k = 0; k < 6; k++) check("cont_order", k, gnt_log[k], exp_g[k]);
        check("cont_cnt", 1, acc_cnt[1], 4);
        check("cont_cnt", 3, acc_cnt[3], 4);
        check("cont_cnt", 6, acc_cnt[6], 4);
        repeat (3) step();
        bus.out_pop[0] = 1'b0;

        // Full: input 0 streams 6 words to output 4 with no pops
        sent = 0;
        set_in(0, 1'b1, 4, 32'hF000_0000);
        repeat (6) begin
            step();
            if (acc[0]) begin
                sent++;
                bus.in_data[0 +: DW] = 32'hF000_0000 + DW'(sent);
            end
        end
        check("full_sent", 0, sent, 4);
        check("full_flag", 4, bus.out_full[4], 1'b1);
        check("full_rdy", 0, bus.in_rdy[0], 1'b0);
        bus.out_pop[4] = 1'b1;
        step();
        bus.out_pop[4] = 1'b0;
        check("full_after_pop", 4, bus.out_full[4], 1'b0);
        step();
        check("full_5th_acc", 0, acc[0], 1'b1);
        if (acc[0]) begin
            sent++;
            bus.in_data[0 +: DW] = 32'hF000_0000 + DW'(sent);
        end
        for (int c = 0; c < 12 && sent < 6; c++) begin
            bus.out_pop[4] = 1'b1;
            step();
            if (acc[0]) sent++;
        end
        bus.in_vld[0]  = 1'b0;
        check("full_all_sent", 0, sent, 6);
        repeat (6) step();
        bus.out_pop[4] = 1'b0;

        // Invalid destination is consumed and flagged for exactly one cycle
        set_in(3, 1'b1, 11, 32'hDEAD_BEEF);
        step();
        check("drop_acc", 3, acc[3], 1'b1);
        check("drop_pulse", 0, bus.drop_err, 1'b1);
        bus.in_vld[3] = 1'b0;
        step();
        check("drop_clear", 0, bus.drop_err, 1'b0);

        // Popping empty FIFOs changes nothing
        bus.out_pop = '1;
        repeat (3) step();
        bus.out_pop = '0;
        check("empty_pop_empty", 0, bus.out_empty, {N{1'b1}});
        check("empty_pop_full", 0, bus.out_full, '0);

`ifdef SWITCH_FABRIC_PRIO_EN
        // Priority input 2 starves input 0 until it withdraws
        bus.in_prio    = '0;
        bus.in_prio[2] = 1'b1;
        set_in(0, 1'b1, 1, 32'h0000_0B00);
        set_in(2, 1'b1, 1, 32'h0000_0B20);
        bus.out_pop[1] = 1'b1;
        repeat (6) begin
            step();
            check("prio_win", 2, acc[2], 1'b1);
            check("prio_lose", 0, acc[0], 1'b0);
            bus.in_data[2*DW +: DW] = bus.in_data[2*DW +: DW] + 32'd1;
        end
        bus.in_vld[2] = 1'b0;
        step();
        check("prio_low_acc", 0, acc[0], 1'b1);
        bus.in_vld  = '0;
        bus.in_prio = '0;
        repeat (4) step();
        bus.out_pop = '0;
`endif

        // Randomized traffic with a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(bus.in_vld[i] && !acc[i])) begin
                    r = int'($urandom_range(0, 99));
                    bus.in_vld[i] = ($urandom_range(0, 99) < 65);
                    if (r < 8)       bus.in_addr[i*AW +: AW] = AW'($urandom_range(N, 15));
                    else if (r < 55) bus.in_addr[i*AW +: AW] = AW'($urandom_range(0, 2));
                    else             bus.in_addr[i*AW +: AW] = AW'($urandom_range(0, N - 1));
                    bus.in_data[i*DW +: DW] = $urandom;
`ifdef SWITCH_FABRIC_PRIO_EN
                    bus.in_prio[i] = ($urandom_range(0, 3) == 0);
`endif
                end
            end
            if (c < 1500) bus.out_pop = N'($urandom | $urandom);
            else          bus.out_pop = N'($urandom & $urandom);
            if (c == 2000) reset_n = 1'b0;
            if (c == 2003) reset_n = 1'b1;
            step();
        end

        bus.in_vld  = '0;
        bus.out_pop = '1;
        repeat (8) step();
        check("final_empty", 0, bus.out_empty, {N{1'b1}});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_fabric.md
# switch_fabric

Parametrised single-clock crossbar core for the router. It accepts one word per input port per cycle with a destination address, arbitrates contending inputs per output with round-robin, and buffers winners in per-output show-ahead FIFOs drained by the egress port logic. It replaces the fixed 8-port mux/FIFO/clear arrangement with a valid/ready handshake and a configurable port count, width and depth.

## Interface
- NPORTS, 8, number of input and output ports (2..16)
- AW, 4, address field width; must satisfy 2**AW >= NPORTS
- DW, 32, payload width
- DEPTH, 4, entries per output FIFO (power of two, >= 2)
- clock  input  1  single clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_vld  input  NPORTS  input i presents a word
- in_addr  input  NPORTS*AW  destination of input i, bits [i*AW +: AW]
- in_data  input  NPORTS*DW  payload of input i, bits [i*DW +: DW]
- in_rdy  output  NPORTS  combinational; transfer on input i when in_vld[i] & in_rdy[i] at a rising edge
- out_pop  input  NPORTS  egress consumes head of output FIFO o
- out_data  output  NPORTS*DW  head entry of FIFO o, registered
- out_empty  output  NPORTS  FIFO o holds no entries
- out_full  output  NPORTS  FIFO o holds DEPTH entries
- drop_err  output  1  one-cycle pulse: a word with in_addr >= NPORTS was discarded

## Operation
- Request: input i requests output o when in_vld[i] and in_addr[i] == o.
- Per-output arbiter: pointer rr[o] (width clog2(NPORTS)). Grant goes to the first requester at index rr[o], rr[o]+1, ... mod NPORTS. No grant while out_full[o].
- in_rdy[i] = 1 iff input i holds the grant of its destination output. Non-granted inputs hold in_vld/in_addr/in_data stable until accepted.
- On a transfer to output o: in_data[i] is written at the FIFO tail; rr[o] <= (i+1) mod NPORTS. rr[o] is unchanged when no transfer occurs.
- Invalid address (in_addr[i] >= NPORTS): in_rdy[i] = 1, word discarded, drop_err registered high for one cycle (OR over inputs).
- FIFO: binary read/write pointers plus occupancy count of clog2(DEPTH+1) bits. Pop when out_pop[o] & !out_empty[o]. out_pop on empty is ignored, no state change.
- Full: push blocked even if out_pop is asserted the same cycle (no full pass-through). Push and pop in the same cycle at 1..DEPTH-1 entries: occupancy unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Reset, including mid-operation: FIFO contents discarded; out_data = 0, out_empty = all ones, out_full = 0, drop_err = 0, all rr = 0. in_rdy is forced to 0 while reset_n is low.

## Timing
- in_rdy is a combinational function of in_vld, in_addr, rr and out_full; no path from in_rdy back to in_vld.
- Push-to-output latency is 1 cycle: a word accepted at edge k into an empty FIFO drives out_data with out_empty = 0 after edge k.
- Pop takes effect at the edge: the next entry, or out_empty = 1, is visible after that edge.
- out_full rises after the edge that writes entry DEPTH and falls after the first pop.
- drop_err is high for the cycle after the discarding edge.
- Throughput: 1 word per output per cycle; all outputs operate concurrently.

## Configuration
- SWITCH_FABRIC_PRIO_EN defined: adds port in_prio (input, NPORTS). At each output, requests with in_prio set win over requests without it. Round-robin from rr[o] applies within the winning class, and rr[o] advances as normal after any grant.
- SWITCH_FABRIC_PRIO_EN undefined: in_prio is absent and arbitration is pure round-robin.

## Test plan
- Reset: hold reset_n low, drive all in_vld = 1 -> in_rdy = 0, out_empty = 8'hFF, out_full = 0, out_data = 0; release -> normal operation.
- Single path: input 2 sends 32'hA5A5_0001 to output 5 -> out_empty[5] = 0 one cycle later, out_data[5] = 32'hA5A5_0001; pop -> out_empty[5] = 1.
- Contention: inputs 1, 3, 6 continuously send to output 0 with out_pop[0] = 1 -> grants in order 1, 3, 6, 1, 3, 6, and each input is accepted exactly once per 3 cycles.
- Full: output 4 never popped, input 0 sends 6 words -> 4 accepted, out_full[4] = 1, in_rdy[0] = 0. Pop once -> the 5th word is accepted the next cycle, and order is preserved.
- Boundary: with NPORTS = 6, in_addr = 7 -> in_rdy = 1, word discarded, drop_err pulses once. Separately, out_pop on an empty FIFO causes no change.
- With SWITCH_FABRIC_PRIO_EN: inputs 0 and 2 send to output 1, with in_prio[2] = 1 -> input 2 wins every cycle, and input 0 is granted only after in_vld[2] falls.
